bcd2bin: RTL and testbench

- Sequential BCD-to-binary converter; the inverse of the combinational binary-to-BCD block used for display.
- Converts a packed DIGITS-digit BCD value (e.g. keypad or parameter entry) into an unsigned binary word.
- Uses reverse double-dabble: shift right, then subtract 3 from any BCD digit that is 8 or more.
- Runs one bit per clock under a start/busy/done handshake, and flags invalid BCD input.

---
 rtl/bcd2bin_if.sv | 18 +
 rtl/bcd2bin.sv | 108 ++++++++++
 tb/tb_bcd2bin.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/bcd2bin_if.sv
// Handshake/data bundle for the sequential BCD-to-binary converter.
// The master issues start/din; the slave returns busy/done/dout/err.
interface bcd2bin_if #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   din;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      dout;
    logic                  err;

    modport master (output start, output din,
                    input  busy,  input  done, input dout, input err);
    modport slave  (input  start, input  din,
                    output busy,  output done, output dout, output err);
endinterface

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one bit per clock.
// Invalid digits (>9) complete immediately with err set and a zero result.
module bcd2bin #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
) (
    input  logic       clk,
    input  logic       rst,
    bcd2bin_if.slave   bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam longint unsigned MAX_BCD = pow10(DIGITS) - 1;

    // The largest decimal operand must fit in the binary result.
    generate
        if (BIN_W < 64 && (64'(1) << BIN_W) <= MAX_BCD) begin : g_bad_width
            $error("bcd2bin: BIN_W too small for DIGITS");
        end
    endgenerate

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e            state_q;
    logic [SR_W-1:0]   sr_q;
    logic [SR_W-1:0]   sr_d;
    logic [SR_W-1:0]   shifted;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [BIN_W-1:0]  dout_q;
    logic              err_q;
    logic              din_ok_c;

    // One reverse double-dabble step: shift right, then correct each BCD digit >= 8.
    always_comb begin
        shifted = sr_q >> 1;
        sr_d    = shifted;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (shifted[BIN_W + 4*d +: 4] >= 4'd8)
                sr_d[BIN_W + 4*d +: 4] = shifted[BIN_W + 4*d +: 4] - 4'd3;
        end
    end

    always_comb begin
        din_ok_c = 1'b1;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (bus.din[4*d +: 4] > 4'd9) din_ok_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (din_ok_c) begin
                            sr_q    <= {bus.din, BIN_W'(0)};
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= SHIFT;
                        end else begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                            dout_q <= '0;
                        end
                    end
                end
                SHIFT: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BIN_W - 1)) begin
                        dout_q  <= sr_d[BIN_W-1:0];
                        err_q   <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dout = dout_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd2bin.sv
// Randomized and directed bench for bcd2bin against a decimal-arithmetic reference model.
module tb_bcd2bin;
    localparam int unsigned DIGITS = 3;
    localparam int unsigned BIN_W  = 10;
    localparam int unsigned BCD_W  = 4 * DIGITS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    bcd2bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd2bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    // Reference: decimal value of the digits, or error with zero result.
    function automatic void ref_model(input logic [BCD_W-1:0] v,
                                      output int unsigned val, output bit bad);
        int unsigned dig;
        val = 0;
        bad = 1'b0;
        for (int d = int'(DIGITS) - 1; d >= 0; d--) begin
            dig = int'(v[4*d +: 4]);
            if (dig > 9) bad = 1'b1;
            val = val * 10 + dig;
        end
        if (bad) val = 0;
    endfunction

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run_one(input logic [BCD_W-1:0] v, input string tag,
                           input bit full, output int done_cyc);
        int unsigned exp_v;
        bit          exp_e;
        int          k;
        int          nbusy;
        ref_model(v, exp_v, exp_e);
        bus.start = 1'b1;
        bus.din   = v;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.din   = BCD_W'($urandom);
        k = 0;
        nbusy = 0;
        while (!bus.done && k < 40) begin
            if (bus.busy) nbusy++;
            @(negedge clk);
            k++;
        end
        done_cyc = cyc;
        check({tag, "_lat"},  64'(k), exp_e ? 64'd0 : 64'(BIN_W));
        check({tag, "_dout"}, 64'(bus.dout), 64'(exp_v));
        check({tag, "_err"},  64'(bus.err), 64'(exp_e));
        if (full) begin
            check({tag, "_nbusy"}, 64'(nbusy), exp_e ? 64'd0 : 64'(BIN_W));
            check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        end
        if (!exp_e)
            check({tag, "_sr_bcd_zero"}, 64'(dut.sr_q[BCD_W+BIN_W-1:BIN_W]), 64'd0);
    endtask

    initial begin
        int dc;
        int prev;
        int k;
        int nd;
        bus.start = 1'b0;
        bus.din   = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_dout", 64'(bus.dout), 64'd0);
        check("rst_err",  64'(bus.err),  64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_one(12'h999, "d999", 1'b1, dc);
        @(negedge clk);
        run_one(12'h511, "d511", 1'b1, dc);
        @(negedge clk);
        run_one(12'h000, "d000", 1'b1, dc);
        @(negedge clk);
        run_one(12'h001, "d001", 1'b1, dc);
        @(negedge clk);
        run_one(12'h1A5, "bad1A5", 1'b1, dc);
        @(negedge clk);
        run_one(12'h042, "d042", 1'b1, dc);
        @(negedge clk);

        // start held high through busy; the done-cycle start is the next accept
        bus.start = 1'b1;
        bus.din   = 12'h123;
        @(posedge clk);
        @(negedge clk);
        bus.din = 12'h456;
        k = 0;
        while (!bus.done && k < 40) begin @(negedge clk); k++; end
        check("hold_lat1",  64'(k), 64'(BIN_W));
        check("hold_dout1", 64'(bus.dout), 64'd123);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        k++;
        check("hold_no_double_done", 64'(bus.done), 64'd0);
        while (!bus.done && k < 60) begin @(negedge clk); k++; end
        check("hold_lat2",  64'(k), 64'(2 * BIN_W + 1));
        check("hold_dout2", 64'(bus.dout), 64'd456);
        @(negedge clk);

        // reset mid-conversion aborts without a done
        bus.start = 1'b1;
        bus.din   = 12'h777;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_dout", 64'(bus.dout), 64'd0);
        check("abort_err",  64'(bus.err),  64'd0);
        rst = 1'b0;
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        check("abort_no_done", 64'(nd), 64'd0);
        run_one(12'h250, "d250", 1'b1, dc);
        @(negedge clk);

        // exhaustive back-to-back sweep
        run_one(12'h000, "sweep_first", 1'b0, prev);
        for (int i = 1; i < 1000; i++) begin
            logic [BCD_W-1:0] v;
            v = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
            run_one(v, "sweep", 1'b0, dc);
            check("sweep_spacing", 64'(dc - prev), 64'(BIN_W + 1));
            prev = dc;
        end

        // random back-to-back burst, invalid codes included
        for (int i = 0; i < 60; i++) begin
            run_one(BCD_W'($urandom), "rand", 1'b1, dc);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
